// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller and its datapath.
package spi_pkg;

  localparam int FRAME_W     = 10;
  localparam int DATA_W      = 8;
  localparam int RD_WAIT_DEF = 3;
  localparam int GAP_DEF     = 1;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CMD,
    ST_SHIFT,
    ST_HOLD,
    ST_WAIT,
    ST_RECV,
    ST_DESEL
  } state_e;

  // States in which the slave must see SS_n driven low.
  function automatic logic ss_active(state_e s);
    return (s inside {ST_SELECT, ST_CMD, ST_SHIFT, ST_HOLD, ST_WAIT, ST_RECV});
  endfunction

  // Command field of a host frame.
  function automatic cmd_e frame_cmd(logic [FRAME_W-1:0] f);
    return cmd_e'(f[FRAME_W-1 -: 2]);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MOSI/MISO datapath: parallel-load MSB-first transmit register and serial-in receive register.
module spi_shift_reg
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               shift_out,
  output logic               tx_bit,
  input  logic               shift_in,
  input  logic               rx_bit,
  output logic [DATA_W-1:0]  rx_word
);

  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-2:0]  rx_q;

  // Transmit register: loaded on accept, shifted left once per transmitted bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
    end else if (load) begin
      tx_q <= load_data;
    end else if (shift_out) begin
      tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
    end
  end

  assign tx_bit = tx_q[FRAME_W-1];

  // Receive register keeps the earlier samples; the newest bit is the live MISO input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q <= '0;
    end else if (load) begin
      rx_q <= '0;
    end else if (shift_in) begin
      rx_q <= {rx_q[DATA_W-3:0], rx_bit};
    end
  end

  assign rx_word = {rx_q, rx_bit};

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: sends one {cmd, payload} frame per host command and returns read-data replies.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int GAP     = GAP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               busy,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  // Terminal counts for the shared slot counter in each counted state.
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT > 1) ? RD_WAIT - 2 : 0);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  cmd_e             cmd_q;
  logic             load;
  logic             shift_out;
  logic             shift_in;
  logic             rsp_fire;
  logic             mosi_next;
  logic             tx_bit;
  logic [DATA_W-1:0] rx_word;

  spi_shift_reg u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (cmd_data),
    .shift_out (shift_out),
    .tx_bit    (tx_bit),
    .shift_in  (shift_in),
    .rx_bit    (MISO),
    .rx_word   (rx_word)
  );

  // State, counter and latched command register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cmd_q <= WR_ADDR;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        cmd_q <= frame_cmd(cmd_data);
      end
    end
  end

  // Next-state, counter and datapath control for the slot sequence.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    shift_out  = 1'b0;
    shift_in   = 1'b0;
    rsp_fire   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_next = ST_SELECT;
          load       = 1'b1;
          cnt_next   = '0;
        end
      end
      ST_SELECT: begin
        state_next = ST_CMD;
      end
      ST_CMD: begin
        state_next = ST_SHIFT;
        cnt_next   = '0;
        shift_out  = 1'b1;
      end
      ST_SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          state_next = ST_HOLD;
        end else begin
          shift_out = 1'b1;
          cnt_next  = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        cnt_next = '0;
        if (cmd_q == RD_DATA) begin
          state_next = (RD_WAIT > 1) ? ST_WAIT : ST_RECV;
        end else begin
          state_next = ST_DESEL;
        end
      end
      ST_WAIT: begin
        if (cnt == WAIT_LAST) begin
          state_next = ST_RECV;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_RECV: begin
        shift_in = 1'b1;
        if (cnt == RECV_LAST) begin
          state_next = ST_DESEL;
          cnt_next   = '0;
          rsp_fire   = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_DESEL: begin
        if (cnt == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The command bit and the serial frame bits come from the top of the transmit register.
  always_comb begin
    mosi_next = 1'b0;
    if (state_next == ST_CMD || state_next == ST_SHIFT) begin
      mosi_next = tx_bit;
    end
  end

  // All outputs are registered from the next state so they change only on posedge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      SS_n      <= ~ss_active(state_next);
      MOSI      <= mosi_next;
      cmd_ready <= (state_next == ST_IDLE);
      busy      <= (state_next != ST_IDLE);
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_data <= rx_word;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave + RAM model.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_data = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        SS_n;
  logic        MOSI;
  logic        MISO = 1'b0;

  int errors = 0;
  int checks = 0;

  // Expected MOSI for 10'h0A5, slot S0 in bit 12 down to S12 in bit 0.
  logic [12:0] mosi_pat = 13'b0_0_0010100101_0;
  logic [9:0]  b2b_cmd [3] = '{10'h020, 10'h15A, 10'h220};

  always #5 clk = ~clk;

  spi_master_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  // Slave model state.
  logic [7:0] mem [256];
  logic [7:0] s_addr = '0;
  logic [9:0] s_shift = '0;
  logic [7:0] s_reply = '0;
  bit         in_frame = 0;
  bit         seen_frame = 0;
  int         slot = 0;
  int         gap_run = 0;
  int         min_gap = 99;
  bit         force_en = 0;
  logic [7:0] force_pat = '0;
  logic [9:0] frame_log [$];

  // Slave model: decodes frames at S12 and drives the reply on MISO in S15..S22.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (SS_n === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1;
          slot = 0;
          if (seen_frame && gap_run < min_gap) min_gap = gap_run;
        end else begin
          slot++;
        end
        if (slot >= 2 && slot <= 11) s_shift = {s_shift[8:0], MOSI};
        if (slot == 12) begin
          frame_log.push_back(s_shift);
          seen_frame = 1;
          case (s_shift[9:8])
            2'b00:   s_addr = s_shift[7:0];
            2'b01:   mem[s_addr] = s_shift[7:0];
            2'b10:   s_addr = s_shift[7:0];
            default: s_reply = force_en ? force_pat : mem[s_addr];
          endcase
        end
        MISO = (slot >= 15 && slot <= 22) ? s_reply[22 - slot] : 1'b0;
      end else begin
        if (in_frame) gap_run = 0;
        in_frame = 0;
        gap_run++;
        MISO = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] frame);
    cmd_data  = frame;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitReady();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (cmd_ready !== 1'b1) checkOutput("ready_timeout", cmd_ready, 1);
  endtask

  // Runs one transaction; slot 0 is S0, returns the slot where cmd_ready came back.
  task automatic runTxn(input logic [9:0] frame, output int ready_slot, output int rsp_count,
                        output int rsp_slot, output logic [7:0] rsp_val);
    int s = 0;
    rsp_count = 0;
    rsp_slot  = -1;
    rsp_val   = 'x;
    applyStimulus(frame);
    while (cmd_ready !== 1'b1 && s < 60) begin
      tick();
      s++;
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        rsp_slot = s;
        rsp_val  = rsp_data;
      end
    end
    ready_slot = s;
  endtask

  initial begin
    int         r, c, ps, base, pulses;
    logic [7:0] v;

    $display("[TB] reset");
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checkOutput("rst_ss_n", SS_n, 1);
    checkOutput("rst_mosi", MOSI, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", cmd_ready, 1);

    $display("[TB] wr_addr 0xA5 slot-by-slot");
    applyStimulus(10'h0A5);
    checkOutput("a5_ready_s0", cmd_ready, 0);
    checkOutput("a5_busy_s0", busy, 1);
    for (int s = 0; s <= 12; s++) begin
      checkOutput($sformatf("a5_ss_n_s%0d", s), SS_n, 0);
      checkOutput($sformatf("a5_mosi_s%0d", s), MOSI, mosi_pat[12 - s]);
      tick();
    end
    checkOutput("a5_ss_n_s13", SS_n, 1);
    checkOutput("a5_busy_s13", busy, 1);
    checkOutput("a5_ready_s13", cmd_ready, 0);
    tick();
    checkOutput("a5_ready_s14", cmd_ready, 1);
    checkOutput("a5_busy_s14", busy, 0);

    $display("[TB] write then read through slave RAM");
    runTxn(10'h010, r, c, ps, v);
    checkOutput("wa_occ", r, 14);
    checkOutput("wa_rsp", c, 0);
    runTxn(10'h13C, r, c, ps, v);
    checkOutput("wd_occ", r, 14);
    runTxn(10'h210, r, c, ps, v);
    checkOutput("ra_occ", r, 14);
    checkOutput("ra_rsp", c, 0);
    runTxn(10'h300, r, c, ps, v);
    checkOutput("rd_occ", r, 24);
    checkOutput("rd_rsp_count", c, 1);
    checkOutput("rd_rsp_slot", ps, 23);
    checkOutput("rd_rsp_data", v, 8'h3C);
    checkOutput("rd_rsp_hold", rsp_data, 8'h3C);
    checkOutput("frames_seen", frame_log.size(), 5);

    $display("[TB] back-to-back with cmd_valid held");
    base = frame_log.size();
    seen_frame = 0;
    min_gap = 99;
    cmd_data  = b2b_cmd[0];
    cmd_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (j > 0) waitReady();
      tick();
      checkOutput($sformatf("b2b_accept%0d", j), cmd_ready, 0);
      if (j < 2) cmd_data = b2b_cmd[j + 1];
    end
    cmd_valid = 1'b0;
    waitReady();
    checkOutput("b2b_frames", frame_log.size() - base, 3);
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("b2b_frame%0d", j), frame_log[base + j], b2b_cmd[j]);
    end
    checkOutput("b2b_gap", min_gap, 2);
    runTxn(10'h300, r, c, ps, v);
    checkOutput("b2b_rd_data", v, 8'h5A);

    $display("[TB] reset during rd_data");
    applyStimulus(10'h300);
    repeat (7) tick();
    checkOutput("abort_ss_n_s7", SS_n, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_ss_n_async", SS_n, 1);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 2) rst_n = 1'b1;
      if (rsp_valid === 1'b1) pulses++;
    end
    checkOutput("abort_no_rsp", pulses, 0);
    checkOutput("abort_ready", cmd_ready, 1);
    checkOutput("abort_busy", busy, 0);
    runTxn(10'h044, r, c, ps, v);
    checkOutput("abort_next_occ", r, 14);
    checkOutput("abort_next_frame", frame_log[frame_log.size() - 1], 10'h044);

    $display("[TB] forced MISO pattern");
    force_en  = 1;
    force_pat = 8'b1001_0110;
    runTxn(10'h300, r, c, ps, v);
    checkOutput("force_rsp_count", c, 1);
    checkOutput("force_rsp_data", v, 8'h96);
    force_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
